// File: rtl/cordic_fix_to_float_pkg.sv
// Shared constants, the converter state type and the float packing helper for cordic_fix_to_float.
// Optional feature macro used by the top: CORDIC_F2F_LZC_EN.
package cordic_fix_to_float_pkg;

    localparam int INTEGER_WIDTH    = 4;
    localparam int FRACTIONAL_WIDTH = 20;
    localparam int FLOAT_DATA_WIDTH = 32;
    localparam int FLOAT_BIAS       = 127;

    localparam logic [31:0] FLOAT_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        F2F_IDLE = 2'd0,
        F2F_NORM = 2'd1,
        F2F_PACK = 2'd2,
        F2F_OUT  = 2'd3
    } f2f_state_e;

    // Assemble an IEEE-754 single from its three fields.
    function automatic logic [31:0] float_pack(input logic sign, input logic [7:0] exp, input logic [22:0] mant);
        return {sign, exp, mant};
    endfunction

endpackage

// File: rtl/cordic_fix_to_float_if.sv
// Valid/ready bus between the CORDIC core, the fixed->float converter and its consumer.
interface cordic_fix_to_float_if #(
    parameter int DW = 24
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   result;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/cordic_fix_to_float_lzc.sv
// Combinational leading-zero counter; only instantiated when CORDIC_F2F_LZC_EN is defined.
module cordic_lzc #(
    parameter  int W  = 24,
    localparam int CW = $clog2(W)
) (
    input  logic [W-1:0]  i_data,
    output logic [CW-1:0] o_count
);

    // Scan upward so the highest set bit writes last; an all-zero input is never normalised.
    always_comb begin
        o_count = '0;
        for (int i = 0; i < W; i++) begin
            if (i_data[i]) begin
                o_count = CW'(W - 1 - i);
            end else begin
                o_count = o_count;
            end
        end
    end

endmodule

// File: rtl/cordic_fix_to_float.sv
// Sequential normaliser turning the CORDIC signed Q4.20 result into an IEEE-754 single.
// Define CORDIC_F2F_LZC_EN to normalise in one cycle with a leading-zero counter.
module cordic_fix_to_float
    import cordic_fix_to_float_pkg::*;
#(
    parameter  int INTEGER_WIDTH    = cordic_fix_to_float_pkg::INTEGER_WIDTH,
    parameter  int FRACTIONAL_WIDTH = cordic_fix_to_float_pkg::FRACTIONAL_WIDTH,
    localparam int W                = INTEGER_WIDTH + FRACTIONAL_WIDTH,
    localparam int CW               = $clog2(W)
) (
    input  logic                  clk,
    input  logic                  rst,
    cordic_fix_to_float_if.slave  bus
);

    f2f_state_e    r_state, w_next_state;
    logic [W-1:0]  r_mag, w_mag_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic          r_sign, w_sign_next;
    logic [31:0]   r_result, w_result_next;
    logic          r_out_valid, w_out_valid_next;
    logic          r_in_ready;
    logic [W-1:0]  w_abs;

    // The most negative input negates to 2^(W-1), which is still representable unsigned.
    assign w_abs = bus.in_data[W-1] ? (~bus.in_data + W'(1'b1)) : bus.in_data;

    // Exponent is bias plus the integer weight of the top bit, minus the shifts taken.
    function automatic logic [31:0] pack_result(input logic s, input logic [W-1:0] m, input logic [CW-1:0] c);
        logic [W+21:0] w_tmp;
        w_tmp = {m[W-2:0], 23'd0};
        return float_pack(s, 8'(FLOAT_BIAS + INTEGER_WIDTH - 1) - 8'(c), w_tmp[W+21 -: 23]);
    endfunction

`ifdef CORDIC_F2F_LZC_EN
    logic [CW-1:0] w_lzc;

    cordic_lzc #(.W(W)) u_lzc (
        .i_data  (r_mag),
        .o_count (w_lzc)
    );
`endif

    // Next-state and datapath update for the conversion FSM.
    always_comb begin
        w_next_state     = r_state;
        w_mag_next       = r_mag;
        w_cnt_next       = r_cnt;
        w_sign_next      = r_sign;
        w_result_next    = r_result;
        w_out_valid_next = r_out_valid;
        case (r_state)
            F2F_IDLE: begin
                if (bus.in_valid) begin
                    w_mag_next  = w_abs;
                    w_cnt_next  = '0;
                    if (w_abs == '0) begin
                        w_sign_next  = 1'b0;
                        w_next_state = F2F_OUT;
                    end else begin
                        w_sign_next  = bus.in_data[W-1];
                        w_next_state = F2F_NORM;
                    end
                end else begin
                    w_next_state = F2F_IDLE;
                end
            end
            F2F_NORM: begin
`ifdef CORDIC_F2F_LZC_EN
                w_mag_next   = r_mag << w_lzc;
                w_cnt_next   = w_lzc;
                w_next_state = F2F_PACK;
`else
                if (r_mag[W-1]) begin
                    w_next_state = F2F_PACK;
                end else begin
                    w_mag_next = r_mag << 1;
                    w_cnt_next = r_cnt + CW'(1'b1);
                end
`endif
            end
            F2F_PACK: begin
                w_result_next    = pack_result(r_sign, r_mag, r_cnt);
                w_out_valid_next = 1'b1;
                w_next_state     = F2F_OUT;
            end
            F2F_OUT: begin
                // Zero input arrives here without a result; it is published one cycle after accept.
                if (!r_out_valid) begin
                    w_result_next    = FLOAT_ZERO;
                    w_out_valid_next = 1'b1;
                end else if (bus.out_ready) begin
                    w_out_valid_next = 1'b0;
                    w_next_state     = F2F_IDLE;
                end else begin
                    w_out_valid_next = 1'b1;
                end
            end
            default: begin
                w_next_state     = F2F_IDLE;
                w_out_valid_next = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= F2F_IDLE;
            r_mag       <= '0;
            r_cnt       <= '0;
            r_sign      <= 1'b0;
            r_result    <= FLOAT_ZERO;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_next_state;
            r_mag       <= w_mag_next;
            r_cnt       <= w_cnt_next;
            r_sign      <= w_sign_next;
            r_result    <= w_result_next;
            r_out_valid <= w_out_valid_next;
            r_in_ready  <= (w_next_state == F2F_IDLE);
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;

endmodule
